// File: rtl/dot_pkg.sv
// Shared types and constants for the dot-product MAC.
// FSM state enum, default sizes, accumulator width derivation.
package dot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int VECTOR_WIDTH_DEF = 4;

  // Full-precision width: product width plus growth for VW additions.
  function automatic int acc_w(input int dw, input int vw);
    return 2 * dw + $clog2(vw);
  endfunction

endpackage

// File: rtl/mac_stage.sv
// Registered multiply followed by accumulate (two pipeline stages).
// Ports: clk, rst_n, clr, in_valid, in_a, in_b -> p_v, acc, sum.
// DOT_SIGNED_EN selects two's-complement operands.
module mac_stage
  import dot_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = acc_w(DATA_WIDTH_DEF, VECTOR_WIDTH_DEF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  p_v,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic [ACC_WIDTH-1:0]  sum
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]        ax;
  logic [PW-1:0]        bx;
  logic [PW-1:0]        prod;
  logic [PW-1:0]        p_r;
  logic [ACC_WIDTH-1:0] p_ext;

  // Operands are widened first; the low PW bits of the
  // product are then exact for both encodings.
`ifdef DOT_SIGNED_EN
  assign ax    = {{DATA_WIDTH{in_a[DATA_WIDTH-1]}}, in_a};
  assign bx    = {{DATA_WIDTH{in_b[DATA_WIDTH-1]}}, in_b};
  assign p_ext = {{(ACC_WIDTH-PW){p_r[PW-1]}}, p_r};
`else
  assign ax    = {{DATA_WIDTH{1'b0}}, in_a};
  assign bx    = {{DATA_WIDTH{1'b0}}, in_b};
  assign p_ext = {{(ACC_WIDTH-PW){1'b0}}, p_r};
`endif

  assign prod = ax * bx;
  assign sum  = acc + p_ext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_r <= '0;
      p_v <= 1'b0;
    end else begin
      p_v <= in_valid;
      if (in_valid)
        p_r <= prod;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (p_v)
      acc <= sum;
  end

endmodule

// File: rtl/dot_product_mac.sv
// Dot-product MAC: FSM, counters and result handshake around mac_stage.
// Ports: clk, rst_n, start, in_a/in_b/in_valid, busy, result,
// result_valid/result_ready, done, drop_err. Macro: DOT_SIGNED_EN.
module dot_product_mac
  import dot_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int VECTOR_WIDTH = VECTOR_WIDTH_DEF,
  parameter int ACC_WIDTH    = acc_w(DATA_WIDTH, VECTOR_WIDTH),
  parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_valid,
  output logic                  busy,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  done,
  output logic                  drop_err
);

  localparam logic [CNT_WIDTH-1:0] VW   = CNT_WIDTH'(VECTOR_WIDTH);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(VECTOR_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  state_t               state;
  logic [CNT_WIDTH-1:0] in_cnt;
  logic [CNT_WIDTH-1:0] acc_cnt;
  logic                 accept;
  logic                 clr;
  logic                 p_v;
  logic                 last_p;
  logic                 hshake;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sum;

  assign accept = (state == ACCUM) && in_valid && (in_cnt < VW);
  assign clr    = (state == IDLE) && start;
  assign last_p = p_v && (acc_cnt == LAST);
  assign hshake = (state == HOLD) && result_valid && result_ready;
  assign busy   = (state != IDLE);

  mac_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (accept),
    .in_a     (in_a),
    .in_b     (in_b),
    .p_v      (p_v),
    .acc      (acc),
    .sum      (sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_cnt       <= '0;
      acc_cnt      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
      drop_err     <= 1'b0;
    end else begin
      drop_err <= in_valid && !accept;
      done     <= hshake;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= ACCUM;
            in_cnt  <= '0;
            acc_cnt <= '0;
          end
        end
        ACCUM: begin
          if (accept)
            in_cnt <= in_cnt + ONE;
          if (p_v)
            acc_cnt <= acc_cnt + ONE;
          if (last_p) begin
            result       <= sum;
            result_valid <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (hshake) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_mac.sv
// Self-checking bench for dot_product_mac: vector table, corner
// sequences, and random vectors against an arithmetic model.
module tb_dot_product_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_valid;
  logic        busy;
  logic [17:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        done;
  logic        drop_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [3:0][1:0] gap;
    int              hold;
    logic [17:0]     exp;
  } vec_t;

  vec_t tbl[5];

  dot_product_mac dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_valid     (in_valid),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .done         (done),
    .drop_err     (drop_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain sum of element products, truncated only
  // at the end to the result width.
  function automatic logic [17:0] model(input vec_t v);
    longint s = 0;
    for (int i = 0; i < 4; i++) begin
`ifdef DOT_SIGNED_EN
      s += longint'($signed(v.a[i])) * longint'($signed(v.b[i]));
`else
      s += longint'(v.a[i]) * longint'(v.b[i]);
`endif
    end
    return 18'(s);
  endfunction

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      repeat (int'(v.gap[i])) step();
      send(v.a[i], v.b[i]);
    end
    chk({tag, "_rv_t1"}, 32'(result_valid), 0);
    step();
    chk({tag, "_rv_t2"}, 32'(result_valid), 1);
    chk({tag, "_result"}, 32'(result), 32'(v.exp));
    for (int i = 0; i < v.hold; i++) begin
      step();
      chk({tag, "_hold_rv"}, 32'(result_valid), 1);
      chk({tag, "_hold_res"}, 32'(result), 32'(v.exp));
      chk({tag, "_hold_done"}, 32'(done), 0);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk({tag, "_hs_rv"}, 32'(result_valid), 0);
    chk({tag, "_hs_done"}, 32'(done), 1);
    chk({tag, "_hs_busy"}, 32'(busy), 0);
    chk({tag, "_hs_res"}, 32'(result), 32'(v.exp));
    step();
    chk({tag, "_done_end"}, 32'(done), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_result"}, 32'(result), 0);
    chk({tag, "_rv"}, 32'(result_valid), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_drop"}, 32'(drop_err), 0);
  endtask

  initial begin
    vec_t rv;
    rst_n        = 1'b0;
    start        = 1'b0;
    in_a         = '0;
    in_b         = '0;
    in_valid     = 1'b0;
    result_ready = 1'b0;

    tbl[0] = '{a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5},
               gap: '0, hold: 0, exp: 18'd70};
    tbl[1] = '{a: {4{8'hFF}}, b: {4{8'hFF}}, gap: '0, hold: 1,
`ifdef DOT_SIGNED_EN
               exp: 18'd4};
`else
               exp: 18'd260100};
`endif
    tbl[2] = '{a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5},
               gap: {2'd3, 2'd1, 2'd2, 2'd1}, hold: 5, exp: 18'd70};
`ifdef DOT_SIGNED_EN
    tbl[3] = '{a: {8'hFE, 8'd3, 8'hFF, 8'h80},
               b: {8'd7, 8'hFC, 8'd5, 8'h80},
               gap: '0, hold: 2, exp: 18'd16353};
    tbl[4] = '{a: {4{8'h80}}, b: {4{8'h80}}, gap: '0, hold: 0,
               exp: 18'd65536};
`else
    tbl[3] = '{a: {8'd0, 8'd255, 8'd0, 8'd1},
               b: {8'd9, 8'd2, 8'd200, 8'd3},
               gap: {2'd0, 2'd2, 2'd0, 2'd1}, hold: 2, exp: 18'd513};
    tbl[4] = '{a: {4{8'd0}}, b: {4{8'd99}}, gap: '0, hold: 0,
               exp: 18'd0};
`endif

    step();
    step();
    chk_reset("reset");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++)
      run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Drops in IDLE, with start, surplus in ACCUM, and in HOLD.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("drop_idle", 32'(drop_err), 1);
    chk("drop_idle_busy", 32'(busy), 0);
    step();
    chk("drop_idle_clr", 32'(drop_err), 0);
    start    = 1'b1;
    in_valid = 1'b1;
    in_a     = 8'd50;
    in_b     = 8'd50;
    step();
    start    = 1'b0;
    in_valid = 1'b0;
    chk("drop_start", 32'(drop_err), 1);
    chk("drop_start_busy", 32'(busy), 1);
    for (int i = 1; i <= 4; i++)
      send(8'(i), 8'(i + 4));
    chk("drop_accum_none", 32'(drop_err), 0);
    send(8'd9, 8'd9);
    chk("drop_surplus", 32'(drop_err), 1);
    chk("drop_surplus_rv", 32'(result_valid), 1);
    chk("drop_surplus_res", 32'(result), 70);
    start = 1'b1;
    send(8'd7, 8'd7);
    start = 1'b0;
    chk("drop_hold", 32'(drop_err), 1);
    chk("drop_hold_busy", 32'(busy), 1);
    chk("drop_hold_rv", 32'(result_valid), 1);
    chk("drop_hold_res", 32'(result), 70);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("drop_hs_done", 32'(done), 1);
    chk("drop_hs_busy", 32'(busy), 0);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("ready_idle_done", 32'(done), 0);
    chk("ready_idle_res", 32'(result), 70);

    // Reset after two pairs, then a fresh operation.
    start = 1'b1;
    step();
    start = 1'b0;
    send(8'd200, 8'd200);
    send(8'd200, 8'd200);
    rst_n = 1'b0;
    step();
    chk_reset("midrst");
    rst_n = 1'b1;
    step();
    rv = '{a: {4{8'd1}}, b: {4{8'd2}}, gap: '0, hold: 0, exp: 18'd8};
    run_vec(rv, "after_rst");

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++) begin
        rv.a[i]   = 8'($urandom);
        rv.b[i]   = 8'($urandom);
        rv.gap[i] = 2'($urandom_range(0, 2));
      end
      rv.hold = int'($urandom_range(0, 3));
      rv.exp  = model(rv);
      run_vec(rv, $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
